// File: rtl/mem_ctrl.sv
`default_nettype none
// =============================================================================
// mem_ctrl : serves 32-bit ME load/store and IF fetch requests over a shared
//            byte-wide synchronous RAM bus, data port having priority.
// Rev 1.0
// =============================================================================
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_r_enable_i,
  input  logic              ram_w_enable_i,
  input  logic [3:0]        ram_w_mask_i,
  input  logic [31:0]       ram_w_data_i,
  input  logic [31:0]       ram_addr_i,
  output logic [31:0]       ram_r_data_o,
  output logic              ram_busy_o,
  output logic              ram_done_o,
  input  logic              inst_req_i,
  input  logic [31:0]       inst_addr_i,
  output logic [31:0]       inst_data_o,
  output logic              inst_done_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-3:0] word_addr;
  logic [2:0]        cnt;
  logic              fetch;
  logic [31:0]       wdata;
  logic [3:0]        wmask;
  logic [23:0]       acc;

  logic [2:0] cnt_nxt;
  logic [1:0] cnt_m1;
  assign cnt_nxt = cnt + 3'd1;
  assign cnt_m1  = cnt[1:0] - 2'd1;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W], ram_addr_i[1:0],
                              inst_addr_i[31:ADDR_W], inst_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      word_addr    <= '0;
      cnt          <= 3'd0;
      fetch        <= 1'b0;
      wdata        <= 32'd0;
      wmask        <= 4'd0;
      acc          <= 24'd0;
      ram_r_data_o <= 32'd0;
      ram_busy_o   <= 1'b0;
      ram_done_o   <= 1'b0;
      inst_data_o  <= 32'd0;
      inst_done_o  <= 1'b0;
      mem_a_o      <= '0;
      mem_dout_o   <= 8'd0;
      mem_wr_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (ram_w_enable_i) begin
            state      <= WR;
            fetch      <= 1'b0;
            ram_busy_o <= 1'b1;
            word_addr  <= ram_addr_i[ADDR_W-1:2];
            wdata      <= ram_w_data_i;
            wmask      <= ram_w_mask_i;
            mem_a_o    <= {ram_addr_i[ADDR_W-1:2], 2'b00};
            mem_dout_o <= ram_w_data_i[7:0];
            mem_wr_o   <= ram_w_mask_i[0];
          end else if (ram_r_enable_i) begin
            state      <= RD;
            fetch      <= 1'b0;
            ram_busy_o <= 1'b1;
            word_addr  <= ram_addr_i[ADDR_W-1:2];
            mem_a_o    <= {ram_addr_i[ADDR_W-1:2], 2'b00};
          end else if (inst_req_i) begin
            state      <= RD;
            fetch      <= 1'b1;
            word_addr  <= inst_addr_i[ADDR_W-1:2];
            mem_a_o    <= {inst_addr_i[ADDR_W-1:2], 2'b00};
          end
        end

        // Every byte takes a cycle regardless of its mask bit: fixed latency.
        WR: begin
          if (cnt == 3'd3) begin
            state      <= DONE;
            mem_a_o    <= '0;
            mem_dout_o <= 8'd0;
            mem_wr_o   <= 1'b0;
            ram_done_o <= 1'b1;
          end else begin
            cnt        <= cnt_nxt;
            mem_a_o    <= {word_addr, cnt_nxt[1:0]};
            mem_dout_o <= wdata[{cnt_nxt[1:0], 3'b000} +: 8];
            mem_wr_o   <= wmask[cnt_nxt[1:0]];
          end
        end

        // RAM returns byte k one cycle after its address, so capture lags by one.
        RD: begin
          cnt <= cnt_nxt;
          if (cnt < 3'd3) begin
            mem_a_o <= {word_addr, cnt_nxt[1:0]};
          end else begin
            mem_a_o <= '0;
          end
          if (cnt == 3'd4) begin
            state <= DONE;
            if (fetch) begin
              inst_data_o <= {mem_din_i, acc};
              inst_done_o <= 1'b1;
            end else begin
              ram_r_data_o <= {mem_din_i, acc};
              ram_done_o   <= 1'b1;
            end
          end else if (cnt != 3'd0) begin
            acc[{cnt_m1, 3'b000} +: 8] <= mem_din_i;
          end
        end

        DONE: begin
          state       <= IDLE;
          ram_done_o  <= 1'b0;
          inst_done_o <= 1'b0;
          ram_busy_o  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// =============================================================================
// tb_mem_ctrl : directed and random accesses checked against a byte-level
//               reference memory; the bus RAM is a separate behavioural model.
// Rev 1.0
// =============================================================================
module tb_mem_ctrl;
  localparam int ADDR_W = 17;
  localparam int OP_LD = 0, OP_ST = 1, OP_IF = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ram_r_enable_i = 1'b0;
  logic              ram_w_enable_i = 1'b0;
  logic [3:0]        ram_w_mask_i = 4'd0;
  logic [31:0]       ram_w_data_i = 32'd0;
  logic [31:0]       ram_addr_i = 32'd0;
  logic [31:0]       ram_r_data_o;
  logic              ram_busy_o;
  logic              ram_done_o;
  logic              inst_req_i = 1'b0;
  logic [31:0]       inst_addr_i = 32'd0;
  logic [31:0]       inst_data_o;
  logic              inst_done_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic [7:0]        mem_din_i = 8'd0;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ram_r_enable_i(ram_r_enable_i), .ram_w_enable_i(ram_w_enable_i),
    .ram_w_mask_i(ram_w_mask_i), .ram_w_data_i(ram_w_data_i), .ram_addr_i(ram_addr_i),
    .ram_r_data_o(ram_r_data_o), .ram_busy_o(ram_busy_o), .ram_done_o(ram_done_o),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .inst_done_o(inst_done_o), .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o),
    .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  // Initial RAM contents, shared by the bus RAM and the reference memory.
  function automatic logic [7:0] seed(input int unsigned a);
    return 8'((a * 37) + ((a >> 8) * 11) + 32'h5A);
  endfunction

  bit [7:0] ram     [0:(1<<ADDR_W)-1];
  bit       written [0:(1<<ADDR_W)-1];

  function automatic logic [7:0] ram_byte(input int unsigned a);
    return written[a] ? ram[a] : seed(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wr_o) begin
      ram[mem_a_o]     <= mem_dout_o;
      written[mem_a_o] <= 1'b1;
    end
    mem_din_i <= ram_byte(32'(mem_a_o));
  end

  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_byte(input int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return seed(a);
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned base);
    return {ref_byte(base + 3), ref_byte(base + 2), ref_byte(base + 1), ref_byte(base)};
  endfunction

  int total = 0, passed = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " busy"}, 32'(ram_busy_o), 32'd0);
    chk({tag, " ram_done"}, 32'(ram_done_o), 32'd0);
    chk({tag, " inst_done"}, 32'(inst_done_o), 32'd0);
    chk({tag, " mem_a"}, 32'(mem_a_o), 32'd0);
    chk({tag, " mem_wr"}, 32'(mem_wr_o), 32'd0);
    chk({tag, " mem_dout"}, 32'(mem_dout_o), 32'd0);
  endtask

  // One complete access; request held until its done pulse, dropped in DONE.
  task automatic access(input int op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input string tag);
    int unsigned base;
    int          lat, n;
    logic        seen;
    logic [31:0] exp_word;
    base     = int'(addr) & ((1 << ADDR_W) - 4);
    lat      = (op == OP_ST) ? 5 : 6;
    exp_word = ref_word(base);
    @(negedge clk);
    ram_w_enable_i = (op == OP_ST);
    ram_r_enable_i = (op == OP_LD);
    inst_req_i     = (op == OP_IF);
    ram_addr_i     = addr;
    inst_addr_i    = addr;
    ram_w_mask_i   = mask;
    ram_w_data_i   = data;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        ram_addr_i   = $urandom;
        inst_addr_i  = $urandom;
        ram_w_data_i = $urandom;
        ram_w_mask_i = 4'($urandom);
      end
      chk({tag, " busy"}, 32'(ram_busy_o), 32'(op != OP_IF));
      if (n <= 4) begin
        chk({tag, " mem_a"}, 32'(mem_a_o), base + n - 1);
        chk({tag, " mem_wr"}, 32'(mem_wr_o), (op == OP_ST) ? 32'(mask[n-1]) : 32'd0);
        if (op == OP_ST) chk({tag, " mem_dout"}, 32'(mem_dout_o), 32'(data[8*(n-1) +: 8]));
      end
      seen = (op == OP_IF) ? inst_done_o : ram_done_o;
    end
    chk({tag, " latency"}, n, lat);
    if (seen) begin
      if (op == OP_LD) chk({tag, " rdata"}, ram_r_data_o, exp_word);
      if (op == OP_IF) chk({tag, " idata"}, inst_data_o, exp_word);
      chk({tag, " other done"}, 32'((op == OP_IF) ? ram_done_o : inst_done_o), 32'd0);
      chk({tag, " done mem_a"}, 32'(mem_a_o), 32'd0);
      chk({tag, " done mem_wr"}, 32'(mem_wr_o), 32'd0);
    end
    ram_w_enable_i = 1'b0;
    ram_r_enable_i = 1'b0;
    inst_req_i     = 1'b0;
    if (op == OP_ST) begin
      for (int k = 0; k < 4; k++) if (mask[k]) ref_mem[base + k] = data[8*k +: 8];
    end
    @(negedge clk);
    chk({tag, " idle busy"}, 32'(ram_busy_o), 32'd0);
    chk({tag, " idle done"}, 32'({ram_done_o, inst_done_o}), 32'd0);
    if (op == OP_ST) begin
      for (int k = 0; k < 4; k++)
        chk({tag, " ram byte"}, 32'(ram_byte(base + k)), 32'(ref_byte(base + k)));
    end
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset rdata", ram_r_data_o, 32'd0);
    chk("reset idata", inst_data_o, 32'd0);
    rst = 1'b1;

    // 1: load of a known word
    access(OP_ST, 32'h0000_0104, 4'b1111, 32'h1234_5678, "t1 st");
    access(OP_LD, 32'h0000_0104, 4'd0, 32'd0, "t1 ld");
    chk("t1 word", ram_r_data_o, 32'h1234_5678);

    // 2: single-byte store
    access(OP_ST, 32'h0000_0202, 4'b0100, 32'hAAAA_AAAA, "t2 sb");
    chk("t2 byte202", 32'(ram_byte(32'h202)), 32'hAA);
    chk("t2 byte200", 32'(ram_byte(32'h200)), 32'(seed(32'h200)));

    // 3: simultaneous load and fetch, load first
    @(negedge clk);
    ram_r_enable_i = 1'b1; ram_addr_i = 32'h104;
    inst_req_i = 1'b1;     inst_addr_i = 32'h200;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk); n++;
      seen = ram_done_o;
      chk("t3 fetch held off", 32'(inst_done_o), 32'd0);
    end
    chk("t3 load latency", n, 6);
    chk("t3 load data", ram_r_data_o, ref_word(32'h104));
    ram_r_enable_i = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk); n++;
      seen = inst_done_o;
      chk("t3 fetch busy", 32'(ram_busy_o), 32'd0);
    end
    chk("t3 fetch latency", n, 7);
    chk("t3 fetch data", inst_data_o, ref_word(32'h200));
    inst_req_i = 1'b0;
    @(negedge clk);

    // 4: reset in the middle of a full-word store
    ram_w_enable_i = 1'b1; ram_w_mask_i = 4'b1111;
    ram_w_data_i = 32'hDDCC_BBEE; ram_addr_i = 32'h300;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("t4 after reset");
    rst = 1'b1;
    ram_w_enable_i = 1'b0;
    ref_mem[32'h300] = 8'hEE;
    ref_mem[32'h301] = 8'hBB;
    for (int k = 0; k < 4; k++)
      chk("t4 ram byte", 32'(ram_byte(32'h300 + k)), 32'(ref_byte(32'h300 + k)));
    access(OP_LD, 32'h300, 4'd0, 32'd0, "t4 ld");

    // 5: exactly one done pulse for one held request
    access(OP_LD, 32'h0000_0400, 4'd0, 32'd0, "t5 ld");
    repeat (6) begin
      @(negedge clk);
      chk("t5 no extra done", 32'({ram_done_o, ram_busy_o}), 32'd0);
    end

    // 6: top-of-space address truncation
    access(OP_ST, 32'hFFFF_FFFC, 4'b1011, 32'hCAFE_F00D, "t6 st");
    access(OP_LD, 32'hFFFF_FFFC, 4'd0, 32'd0, "t6 ld");
    access(OP_IF, 32'hFFFF_FFFE, 4'd0, 32'd0, "t6 if");

    // Random mix in a small window so loads see earlier stores
    for (int i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFE_0000) | (32'h400 + $urandom_range(0, 31));
      access($urandom_range(0, 2), a, 4'($urandom), $urandom, "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
